stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, shall set the number of requesting ready/valid sources (2..8).
REQ-002 Parameter WIDTH, default 8, shall set the data beat width.
REQ-003 Parameter MAX_BURST, default 4, shall set the maximum beats per grant (1..255).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  NUM_SRC  per-source beat valid.
REQ-007 s_data  input  NUM_SRC*WIDTH  per-source beat; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 s_ready  output  NUM_SRC  per-source accept.
REQ-009 m_valid  output  1  registered output beat valid.
REQ-010 m_data  output  WIDTH  registered output beat.
REQ-011 m_src  output  clog2(NUM_SRC)  source index of the current m_data.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 busy  output  1  high while in GRANT.

Function
REQ-014 The controller shall have two states: IDLE and GRANT.
REQ-015 In IDLE with any s_valid high, the controller shall choose the first set bit at or after rr_ptr, searching upward with wrap-around, latch it as grant, clear burst_cnt, and enter GRANT on the next edge.
REQ-016 In IDLE with no s_valid high, the controller shall remain in IDLE.
REQ-017 s_ready[i] shall be combinational: high only when state==GRANT, grant==i, and (m_valid==0 or m_ready==1); all other s_ready bits shall be 0.
REQ-018 A beat shall transfer when s_valid[grant] and s_ready[grant] are both high; on the next edge, m_data shall take s_data[grant], m_src shall take grant, and m_valid shall be 1 (latency 1 cycle).
REQ-019 When m_valid and m_ready are high and no new beat transfers, m_valid shall clear on the next edge; m_data and m_src shall hold.
REQ-020 While m_valid is high and m_ready is low, m_valid, m_data and m_src shall hold.
REQ-021 The datapath shall sustain one beat per cycle inside a grant when m_ready is held high.
REQ-022 burst_cnt shall increment on each transferred beat; the transfer that takes it to MAX_BURST shall end the grant.
REQ-023 A cycle in GRANT where s_ready[grant] is high and s_valid[grant] is low shall end the grant without a transfer.
REQ-024 On grant end, rr_ptr shall become (grant+1) mod NUM_SRC, and the state shall return to IDLE on the same edge.
REQ-025 A grant end shall therefore cost exactly one IDLE arbitration cycle before the next grant.
REQ-026 Requests from non-granted sources arriving during GRANT shall wait; they shall not change the grant.
REQ-027 With MAX_BURST=1, every beat shall be its own grant, with strict rotation among active sources.
REQ-028 busy shall be high exactly when state==GRANT.

Reset
REQ-029 On rst_n low, the block shall immediately set state=IDLE, rr_ptr=0, grant=0, burst_cnt=0, m_valid=0, m_data=0, m_src=0, busy=0, s_ready=0.
REQ-030 Reset during GRANT or with a pending output beat shall discard that beat; after release, arbitration shall restart from source 0.
REQ-031 The first possible grant shall fall in the first IDLE cycle after rst_n deasserts.

Structure
REQ-032 A shared package shall hold the arb_state_t enum (IDLE, GRANT) and the default constants NUM_SRC, WIDTH and MAX_BURST.
REQ-033 The rotating-priority search shall be a combinational sub-module rr_select, with inputs req[NUM_SRC] and ptr, and outputs gnt_idx and gnt_any.
REQ-034 The top level shall contain the FSM, burst counter, rr_ptr and output register.

Verification
REQ-035 Single source: s_valid=4'b0010 with beats 0x11, 0x22, 0x33 and m_ready=1 -> m_data 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after the first s_valid, all with m_src=1.
REQ-036 All sources saturated: NUM_SRC=4, MAX_BURST=4, m_ready=1 -> m_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., with one bubble between bursts.
REQ-037 Backpressure: hold m_ready=0 for 5 cycles mid-burst -> m_data is stable, all s_ready=0, and no beat is lost or duplicated.
REQ-038 Early release: source 2 drops s_valid after 2 beats while source 3 is requesting -> the grant ends, rr_ptr=3, and the next m_src=3.
REQ-039 Fairness wrap: rr_ptr=3 with requests 4'b1001 -> the grant goes to 3 first, then to 0.
REQ-040 Reset mid-burst: assert rst_n low while m_valid=1 -> all outputs are 0 immediately, and after release, with requests 4'b1111, the first m_src=0.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter.
//   arb_state_t   : controller state (IDLE arbitrates, GRANT streams one source)
//   DEF_NUM_SRC   : default number of sources
//   DEF_WIDTH     : default beat width
//   DEF_MAX_BURST : default beats per grant
package stream_rr_arbiter_pkg;

  localparam int unsigned DEF_NUM_SRC   = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_select.sv
// Rotating-priority selector: returns the first set request at or after ptr,
// searching upward and wrapping around.
//   req     : request vector, one bit per source
//   ptr     : index with highest priority this cycle
//   gnt_idx : winning source index (0 when nothing requests)
//   gnt_any : at least one request is set
module rr_select
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int unsigned SrcW = $clog2(NUM_SRC);
  localparam int unsigned SumW = SrcW + 1;

  logic [SumW-1:0] sum;
  logic [SrcW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      // ptr + off is below 2*NUM_SRC, so one conditional subtract is a full modulo.
      sum = {1'b0, ptr} + SumW'(off);
      if (sum >= SumW'(NUM_SRC)) begin
        sum = sum - SumW'(NUM_SRC);
      end
      idx = sum[SrcW-1:0];
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC ready/valid streams into one registered
// output stream. A grant lasts up to MAX_BURST beats, or until the granted
// source stops offering data; each grant end costs one IDLE arbitration cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_valid    : per-source beat valid
//   s_data     : per-source beats, source i at [i*WIDTH +: WIDTH]
//   s_ready    : per-source accept (only the granted source, when output has room)
//   m_valid    : registered output beat valid
//   m_data     : registered output beat
//   m_src      : source index of m_data
//   m_ready    : downstream accept
//   busy       : high while a grant is active
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         s_valid,
  input  logic [NUM_SRC*WIDTH-1:0]   s_data,
  output logic [NUM_SRC-1:0]         s_ready,
  output logic                       m_valid,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(NUM_SRC)-1:0] m_src,
  input  logic                       m_ready,
  output logic                       busy
);

  localparam int unsigned SrcW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_t      state_q, state_d;
  logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SrcW-1:0] grant_q, grant_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [SrcW-1:0] m_src_q, m_src_d;

  logic [SrcW-1:0]  sel_idx;
  logic             sel_any;
  logic             out_free;
  logic             gnt_valid;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;
  logic             burst_last;
  logic [SrcW-1:0]  ptr_next;

  rr_select #(
    .NUM_SRC(NUM_SRC)
  ) u_rr_select (
    .req    (s_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(sel_idx),
    .gnt_any(sel_any)
  );

  // The output register can take a beat when empty or being drained this cycle.
  assign out_free   = !m_valid_q || m_ready;
  assign gnt_valid  = s_valid[grant_q];
  assign gnt_data   = s_data[grant_q*WIDTH +: WIDTH];
  assign xfer       = (state_q == GRANT) && out_free && gnt_valid;
  assign burst_last = (burst_cnt_q + CntW'(1)) == CntW'(MAX_BURST);
  assign ptr_next   = (grant_q == SrcW'(NUM_SRC - 1)) ? '0 : grant_q + SrcW'(1);

  always_comb begin
    s_ready = '0;
    if ((state_q == GRANT) && out_free) begin
      s_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_d     = sel_idx;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Offered a slot: either take the beat, or end on an idle source.
        if (out_free) begin
          if (gnt_valid) begin
            burst_cnt_d = burst_cnt_q + CntW'(1);
            if (burst_last) begin
              state_d  = IDLE;
              rr_ptr_d = ptr_next;
            end
          end else begin
            state_d  = IDLE;
            rr_ptr_d = ptr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = gnt_data;
      m_src_d   = grant_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_src_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_src_q     <= m_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (4 sources, 8-bit beats, bursts of 4).
// Each source is fed from a bench FIFO; a transaction-level reference model
// predicts s_ready and the output register every cycle, and directed scenarios
// compare the accepted output stream against hand-built expected lists.
module tb_stream_rr_arbiter;

  localparam int NS = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic            clk;
  logic            rst_n;
  logic [NS-1:0]   s_valid;
  logic [NS*W-1:0] s_data;
  logic [NS-1:0]   s_ready;
  logic            m_valid;
  logic [W-1:0]    m_data;
  logic [1:0]      m_src;
  logic            m_ready;
  logic            busy;

  stream_rr_arbiter #(
    .NUM_SRC  (NS),
    .WIDTH    (W),
    .MAX_BURST(MB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_src  (m_src),
    .m_ready(m_ready),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-source beat FIFOs
  logic [W-1:0] fifo [NS][256];
  int           hd [NS];
  int           tl [NS];
  logic [NS-1:0] en;

  // Reference model: grant owner, beats taken in this grant, next priority, output reg
  bit         act;
  int         own;
  int         beats;
  int         nxt;
  logic       mv;
  logic [W-1:0] md;
  int         ms;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [W-1:0] v);
    fifo[s][tl[s] % 256] = v;
    tl[s]++;
  endtask

  task automatic model_reset();
    act = 1'b0; own = 0; beats = 0; nxt = 0;
    mv = 1'b0; md = '0; ms = 0;
    for (int i = 0; i < NS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    obs_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic tick(input logic mr);
    logic [NS-1:0] exp_rdy;
    bit space;
    bit moved;
    int c;
    m_ready = mr;
    for (int i = 0; i < NS; i++) begin
      s_valid[i]       = en[i] && (tl[i] != hd[i]);
      s_data[i*W +: W] = (tl[i] != hd[i]) ? fifo[i][hd[i] % 256] : '0;
    end
    #1;
    space   = !mv || mr;
    exp_rdy = '0;
    if (act && space) exp_rdy[own] = 1'b1;
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    chk("m_valid", 32'(m_valid), 32'(mv));
    chk("m_data", 32'(m_data), 32'(md));
    chk("m_src", 32'(m_src), 32'(ms));
    chk("busy", 32'(busy), 32'(act));
    if (m_valid === 1'b1 && mr) obs_q.push_back({6'b0, m_src, m_data});

    moved = act && space && s_valid[own];
    if (moved) begin
      mv = 1'b1;
      md = fifo[own][hd[own] % 256];
      ms = own;
      hd[own]++;
    end else if (mr) begin
      mv = 1'b0;
    end
    if (!act) begin
      for (int k = 0; k < NS; k++) begin
        c = (nxt + k) % NS;
        if (!act && s_valid[c]) begin
          act = 1'b1; own = c; beats = 0;
        end
      end
    end else if (space) begin
      if (s_valid[own]) beats++;
      if (!s_valid[own] || beats == MB) begin
        act = 1'b0;
        nxt = (own + 1) % NS;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic mr);
    for (int i = 0; i < n; i++) tick(mr);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) begin
      chk(tag, (k < obs_q.size()) ? {16'b0, obs_q[k]} : 32'hxxxx_xxxx, {16'b0, exp_q[k]});
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    s_valid = '0;
    s_data  = '0;
    m_ready = 1'b0;
    en      = '1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_src", 32'(m_src), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, three beats back to back
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
    run(2, 1'b1);
    chk("single_d0", 32'(m_data), 32'h11);
    chk("single_s0", 32'(m_src), 1);
    chk("single_v0", 32'(m_valid), 1);
    tick(1'b1);
    chk("single_d1", 32'(m_data), 32'h22);
    tick(1'b1);
    chk("single_d2", 32'(m_data), 32'h33);
    run(3, 1'b1);

    // All sources saturated: bursts of four in rotation
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 8; k++) push(s, 8'((s << 4) | k));
    run(48, 1'b1);
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      int src;
      int seq;
      src = (k / 4) % 4;
      seq = (k / 16) * 4 + (k % 4);
      exp_q.push_back(16'((src << 8) | (src << 4) | seq));
    end
    chk_stream("saturate");

    // Backpressure mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 8'hA0 + 8'(k));
    run(3, 1'b1);
    chk("bp_pre", 32'(m_data), 32'hA1);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0);
      chk("bp_hold_data", 32'(m_data), 32'hA1);
      chk("bp_hold_ready", 32'(s_ready), 0);
    end
    run(8, 1'b1);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h00A0 + 16'(k));
    chk_stream("backpressure");

    // Early release of source 2 hands over to source 3
    do_reset();
    push(2, 8'h21); push(2, 8'h22);
    push(3, 8'h31); push(3, 8'h32);
    run(12, 1'b1);
    exp_q = '{16'h0221, 16'h0222, 16'h0331, 16'h0332};
    chk_stream("early_release");

    // Priority sitting at 3 with requests 1001: 3 wins before 0
    do_reset();
    push(2, 8'h2A);
    run(4, 1'b1);
    push(0, 8'h0A); push(3, 8'h3A);
    run(10, 1'b1);
    exp_q = '{16'h022A, 16'h033A, 16'h000A};
    chk_stream("wrap");

    // Reset while a beat is pending
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h51 + 8'(k));
    run(3, 1'b1);
    chk("mid_pre_valid", 32'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 32'(m_valid), 0);
    chk("mid_m_data", 32'(m_data), 0);
    chk("mid_m_src", 32'(m_src), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_s_ready", 32'(s_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) push(s, 8'h60 + 8'(s));
    run(14, 1'b1);
    chk("mid_first_src", (obs_q.size() > 0) ? {16'b0, obs_q[0]} : 32'hxxxx_xxxx, 32'h0060);

    // Random traffic, valids toggling and random downstream stalls
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int s = 0; s < NS; s++) begin
        if ((tl[s] - hd[s]) < 6 && ($urandom % 3) == 0) push(s, 8'($urandom));
      end
      en = ($urandom % 4 == 0) ? 4'($urandom) : '1;
      tick(($urandom % 4) != 0);
    end
    en = '1;
    run(60, 1'b1);
    for (int s = 0; s < NS; s++) chk("rand_drained", 32'(tl[s] - hd[s]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
